dfswt_peak_detect: RTL and testbench

- Sits directly downstream of one dfswt_stage and consumes its `magnitude` output on the same `enable` sample strobe.
- Groups samples into fixed frames and reports, per frame, the peak magnitude, the sample index of that peak and the summed frame energy.
- Maintains a hysteresis-filtered tone `detected` flag that the control logic downstream uses.

---
 rtl/dfswt_peak_detect_if.sv | 25 ++
 rtl/dfswt_peak_detect.sv | 157 +++++++++++++++
 tb/tb_dfswt_peak_detect.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dfswt_peak_detect_if.sv
// Bundle for the peak detector: frame/sample controls in, per-frame results out.
// The master drives run/enable/magnitude/threshold; the slave (the detector) drives the results.
interface dfswt_peak_detect_if #(
  parameter int FRAME_BITS = 8
);
  logic                       run;
  logic                       enable;
  logic [31:0]                magnitude;
  logic [31:0]                threshold;
  logic                       frame_valid;
  logic [31:0]                peak_mag;
  logic [FRAME_BITS-1:0]      peak_index;
  logic [32+FRAME_BITS-1:0]   energy;
  logic                       detected;

  modport master (
    output run, enable, magnitude, threshold,
    input  frame_valid, peak_mag, peak_index, energy, detected
  );

  modport slave (
    input  run, enable, magnitude, threshold,
    output frame_valid, peak_mag, peak_index, energy, detected
  );
endinterface

// File: rtl/dfswt_peak_detect.sv
// Per-frame peak/index/energy reporter with a hysteresis tone flag, fed by a dfswt_stage.
// Optional macro DFSWT_PEAK_ENERGY_EN builds the energy accumulator; otherwise energy is tied to 0.
module dfswt_peak_detect #(
  parameter int FRAME      = 256,
  parameter int FRAME_BITS = 8,
  parameter int HOLD       = 2
) (
  input  logic               clock,
  input  logic               reset,
  dfswt_peak_detect_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam int                    EW      = 32 + FRAME_BITS;
  localparam logic [FRAME_BITS-1:0] LAST    = FRAME_BITS'(FRAME - 1);
  localparam logic [3:0]            HOLD_M1 = 4'(HOLD - 1);

  logic [1:0]            r_state;
  logic [FRAME_BITS-1:0] r_count;
  logic [31:0]           r_peak;
  logic [FRAME_BITS-1:0] r_index;
  logic [3:0]            r_hc;
  logic                  r_frame_valid;
  logic [31:0]           r_peak_mag;
  logic [FRAME_BITS-1:0] r_peak_index;
  logic                  r_detected;

  logic                  w_first;
  logic                  w_greater;
  logic                  w_take;
  logic                  w_last;
  logic                  w_above;
  logic                  w_flip;
  logic [31:0]           w_peak_next;
  logic [FRAME_BITS-1:0] w_index_next;

  // The counter is already 0 in REPORT, so a sample taken there becomes sample 0 of the next frame.
  assign w_take       = bus.run && bus.enable && (r_state == S_ACCUM || r_state == S_REPORT);
  assign w_last       = w_take && (r_count == LAST);
  assign w_first      = (r_count == '0);
  assign w_greater    = bus.magnitude > r_peak;
  assign w_peak_next  = (w_first || w_greater) ? bus.magnitude : r_peak;
  assign w_index_next = w_first ? '0 : (w_greater ? r_count : r_index);
  assign w_above      = r_peak_mag > bus.threshold;
  assign w_flip       = r_detected ? !w_above : w_above;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_peak        <= '0;
      r_index       <= '0;
      r_hc          <= '0;
      r_frame_valid <= 1'b0;
      r_peak_mag    <= '0;
      r_peak_index  <= '0;
      r_detected    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            r_state <= S_ACCUM;
            r_count <= '0;
          end
        end
        S_ACCUM: begin
          if (!bus.run) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (bus.enable) begin
            r_peak  <= w_peak_next;
            r_index <= w_index_next;
            // Results are registered on the accepting edge so they are visible in REPORT.
            if (w_last) begin
              r_count       <= '0;
              r_state       <= S_REPORT;
              r_frame_valid <= 1'b1;
              r_peak_mag    <= w_peak_next;
              r_peak_index  <= w_index_next;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (w_flip) begin
            if (r_hc == HOLD_M1) begin
              r_detected <= ~r_detected;
              r_hc       <= '0;
            end else begin
              r_hc <= r_hc + 4'd1;
            end
          end else begin
            r_hc <= '0;
          end
          if (bus.run) begin
            r_state <= S_ACCUM;
            if (bus.enable) begin
              r_peak  <= w_peak_next;
              r_index <= w_index_next;
              r_count <= FRAME_BITS'(1);
            end else begin
              r_count <= '0;
            end
          end else begin
            r_state <= S_IDLE;
            r_count <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.peak_mag    = r_peak_mag;
  assign bus.peak_index  = r_peak_index;
  assign bus.detected    = r_detected;

`ifdef DFSWT_PEAK_ENERGY_EN
  logic [EW-1:0] r_energy;
  logic [EW-1:0] r_energy_out;
  logic [EW-1:0] w_mag_ext;
  logic [EW-1:0] w_energy_next;

  assign w_mag_ext     = EW'(bus.magnitude);
  assign w_energy_next = w_first ? w_mag_ext : (r_energy + w_mag_ext);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_energy     <= '0;
      r_energy_out <= '0;
    end else begin
      if (w_take) begin
        r_energy <= w_energy_next;
      end
      if (w_last) begin
        r_energy_out <= w_energy_next;
      end
    end
  end

  assign bus.energy = r_energy_out;
`else
  assign bus.energy = '0;
`endif

  a_fv_in_report: assert property (@(posedge clock) disable iff (!reset)
    bus.frame_valid |-> (r_state == S_REPORT));
  a_state_legal: assert property (@(posedge clock) disable iff (!reset)
    r_state != 2'd3);

endmodule

// File: tb/tb_dfswt_peak_detect.sv
// Directed bench for dfswt_peak_detect with FRAME=8, HOLD=2: table of frames plus hand-written corner sequences.
// Energy expectations follow DFSWT_PEAK_ENERGY_EN (0 when the accumulator is not built).
module tb_dfswt_peak_detect;
  localparam int FRAME = 8;
  localparam int FB    = 3;
  localparam int HOLD  = 2;
`ifdef DFSWT_PEAK_ENERGY_EN
  localparam bit ENERGY_EN = 1'b1;
`else
  localparam bit ENERGY_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dfswt_peak_detect_if #(.FRAME_BITS(FB)) bus ();

  dfswt_peak_detect #(.FRAME(FRAME), .FRAME_BITS(FB), .HOLD(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int fv_count = 0;

  always @(posedge clock) if (bus.frame_valid === 1'b1) fv_count++;

  typedef struct packed {
    logic [7:0][31:0] mag;
    logic [31:0]      thr;
    logic [3:0]       gap;
    logic [31:0]      peak;
    logic [2:0]       idx;
    logic [63:0]      nrg;
    logic             det;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [31:0] m0, m1, m2, m3, m4, m5, m6, m7,
                                  input logic [31:0] thr, input int gap, input logic [31:0] peak,
                                  input int idx, input logic [63:0] nrg, input bit det);
    vec_t v;
    v.mag[0] = m0; v.mag[1] = m1; v.mag[2] = m2; v.mag[3] = m3;
    v.mag[4] = m4; v.mag[5] = m5; v.mag[6] = m6; v.mag[7] = m7;
    v.thr  = thr;
    v.gap  = 4'(gap);
    v.peak = peak;
    v.idx  = 3'(idx);
    v.nrg  = nrg;
    v.det  = det;
    vecs.push_back(v);
  endfunction

  function automatic logic [63:0] exp_nrg(input logic [63:0] n);
    return ENERGY_EN ? n : 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] m, input int gap);
    bus.enable = 1'b0;
    repeat (gap) @(negedge clock);
    bus.enable    = 1'b1;
    bus.magnitude = m;
    @(negedge clock);
    bus.enable = 1'b0;
  endtask

  // Called at the negedge right after the edge that accepted the last sample.
  task automatic check_frame(input string tag, input logic [31:0] peak, input int idx, input logic [63:0] nrg);
    check({tag, " frame_valid"}, 64'(bus.frame_valid), 64'd1);
    check({tag, " peak_mag"},    64'(bus.peak_mag),    64'(peak));
    check({tag, " peak_index"},  64'(bus.peak_index),  64'(idx));
    check({tag, " energy"},      64'(bus.energy),      exp_nrg(nrg));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " frame_valid"}, 64'(bus.frame_valid), 64'd0);
    check({tag, " peak_mag"},    64'(bus.peak_mag),    64'd0);
    check({tag, " peak_index"},  64'(bus.peak_index),  64'd0);
    check({tag, " energy"},      64'(bus.energy),      64'd0);
    check({tag, " detected"},    64'(bus.detected),    64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    bus.run       = 1'b0;
    bus.enable    = 1'b0;
    bus.magnitude = '0;
    bus.threshold = 32'd100;

    // Table: mags, threshold, gap, expected peak, index, energy, detected after REPORT
    add_vec(5, 9, 3, 9, 1, 2, 7, 4,           100, 0, 9,   1, 40,  1'b0);
    add_vec(10, 20, 30, 150, 40, 150, 0, 1,   100, 1, 150, 3, 401, 1'b0);
    add_vec(50, 50, 50, 50, 50, 50, 50, 50,   100, 0, 50,  0, 400, 1'b0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 150,         100, 2, 150, 7, 150, 1'b0);
    add_vec(150, 1, 2, 3, 4, 5, 6, 7,         100, 0, 150, 0, 178, 1'b1);
    add_vec(1, 2, 3, 4, 5, 6, 7, 50,          100, 1, 50,  7, 78,  1'b1);
    add_vec(100, 101, 150, 149, 0, 0, 0, 0,   100, 0, 150, 2, 500, 1'b1);
    add_vec(100, 100, 100, 100, 100, 100, 100, 50, 100, 0, 100, 0, 750, 1'b1);
    add_vec(3, 50, 7, 0, 0, 0, 0, 0,          100, 1, 50,  1, 60,  1'b0);
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            100, 0, 32'hFFFFFFFF, 0, 64'h7_FFFF_FFF8, 1'b0);

    // Reset and idle
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    for (int k = 0; k < 20; k++) send(32'hDEAD_0000 + 32'(k), 1);
    check_zero("idle");
    check("idle fv_count", 64'(fv_count), 64'd0);

    // Table-driven frames, run held high throughout
    bus.run = 1'b1;
    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.threshold = vecs[i].thr;
      for (int j = 0; j < FRAME; j++) send(vecs[i].mag[j], int'(vecs[i].gap));
      check_frame($sformatf("v%0d", i), vecs[i].peak, int'(vecs[i].idx), vecs[i].nrg);
      @(negedge clock);
      check($sformatf("v%0d fv_pulse", i), 64'(bus.frame_valid), 64'd0);
      check($sformatf("v%0d detected", i), 64'(bus.detected), 64'(vecs[i].det));
    end

    // Back-to-back with gaps; sample 9 arrives in the REPORT cycle
    fc0 = fv_count;
    for (int k = 1; k <= 8; k++) send(32'(10 * k), 2);
    check_frame("b2b1", 80, 7, 360);
    send(500, 0);
    for (int k = 10; k <= 16; k++) send(32'(10 * k), 2);
    check_frame("b2b2", 500, 0, 1410);
    @(negedge clock);
    check("b2b fv_count", 64'(fv_count - fc0), 64'd2);

    // Abort after 5 samples; the sample on the run-falling edge is discarded
    fc0 = fv_count;
    for (int k = 0; k < 5; k++) send(1000, 0);
    bus.run       = 1'b0;
    bus.enable    = 1'b1;
    bus.magnitude = 2000;
    @(negedge clock);
    bus.enable = 1'b0;
    repeat (3) @(negedge clock);
    check("abort fv_count",  64'(fv_count - fc0), 64'd0);
    check("abort peak_mag",  64'(bus.peak_mag),   64'd500);
    check("abort energy",    64'(bus.energy),     exp_nrg(1410));
    bus.threshold = 32'd0;
    bus.run       = 1'b1;
    @(negedge clock);
    for (int k = 0; k < FRAME; k++) send(32'(7 - k), 0);
    check_frame("abort next", 7, 0, 28);
    @(negedge clock);
    check("abort next fv_count", 64'(fv_count - fc0), 64'd1);
    check("abort hc retained", 64'(bus.detected), 64'd1);

    // Reset mid-frame, then an ignored enable in the IDLE->ACCUM transition cycle
    for (int k = 0; k < 6; k++) send(32'(100 + k), 0);
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.magnitude = 999;
    @(negedge clock);
    reset         = 1'b1;
    bus.magnitude = 77777;
    check_zero("midreset");
    @(negedge clock);
    bus.enable = 1'b0;
    for (int k = 0; k < FRAME; k++) send(32'(k + 1), 0);
    check_frame("post reset", 8, 7, 36);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
